// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage
//  Description : PC register, instruction-memory addressing and F/D latch,
//                with early j/jal redirect and late execute redirect.
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_stage #(
    parameter int                  PC_WIDTH = 12,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                stall,
    input  logic                redirect_valid,
    input  logic [PC_WIDTH-1:0] redirect_pc,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic [31:0]         imem_data,
    output logic [31:0]         fd_insn,
    output logic [PC_WIDTH-1:0] fd_pc,
    output logic                fd_valid,
    output logic                fd_predicted
);

    localparam logic [4:0] c_OP_J   = 5'b00001;
    localparam logic [4:0] c_OP_JAL = 5'b00011;

    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [31:0]         fd_insn_q, fd_insn_d;
    logic [PC_WIDTH-1:0] fd_pc_q, fd_pc_d;
    logic                fd_valid_q, fd_valid_d;
    logic                fd_predicted_q, fd_predicted_d;

    logic [4:0]          w_op;
    logic                w_early_jump;
    logic [PC_WIDTH-1:0] w_seq_pc;
    logic [PC_WIDTH-1:0] w_target;

    assign w_op         = imem_data[31:27];
    assign w_early_jump = (w_op == c_OP_J) || (w_op == c_OP_JAL);
    assign w_seq_pc     = pc_q + {{(PC_WIDTH-1){1'b0}}, 1'b1};
    // Target bits above the PC width are dropped; jumps land modulo 2^PC_WIDTH.
    assign w_target     = imem_data[PC_WIDTH-1:0];

    always_comb begin
        pc_d           = pc_q;
        fd_insn_d      = fd_insn_q;
        fd_pc_d        = fd_pc_q;
        fd_valid_d     = fd_valid_q;
        fd_predicted_d = fd_predicted_q;
        if (redirect_valid) begin
            // The fetched word is never looked at here, so an undefined
            // imem_data on a flush cycle cannot leak into the latch.
            pc_d           = redirect_pc;
            fd_insn_d      = '0;
            fd_pc_d        = '0;
            fd_valid_d     = 1'b0;
            fd_predicted_d = 1'b0;
        end else if (!stall) begin
            pc_d           = w_early_jump ? w_target : w_seq_pc;
            fd_insn_d      = imem_data;
            fd_pc_d        = w_seq_pc;
            fd_valid_d     = 1'b1;
            fd_predicted_d = w_early_jump;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q           <= RESET_PC;
            fd_insn_q      <= '0;
            fd_pc_q        <= '0;
            fd_valid_q     <= 1'b0;
            fd_predicted_q <= 1'b0;
        end else begin
            pc_q           <= pc_d;
            fd_insn_q      <= fd_insn_d;
            fd_pc_q        <= fd_pc_d;
            fd_valid_q     <= fd_valid_d;
            fd_predicted_q <= fd_predicted_d;
        end
    end

    assign imem_addr    = pc_q;
    assign fd_insn      = fd_insn_q;
    assign fd_pc        = fd_pc_q;
    assign fd_valid     = fd_valid_q;
    assign fd_predicted = fd_predicted_q;

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage and F/D pipeline register for the 5-stage core.
- Holds the PC, drives instruction-memory address, captures the returned instruction word into the F/D latch.
- F/D latch output feeds the decode stage: fd_insn[31:27] goes directly to the opcode decoder.
- Handles stall, late redirect/flush from execute, and early redirect of j/jal (opcodes 00001/00011) at fetch.

Parameters:
- PC_WIDTH, 12, width of PC and imem address; PC arithmetic is modulo 2^PC_WIDTH.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  hazard unit holds PC and F/D latch.
- redirect_valid  input  1  execute-stage branch taken/jr/bex; flushes fetch.
- redirect_pc  input  PC_WIDTH  target PC for redirect_valid.
- imem_addr  output  PC_WIDTH  combinational copy of PC register.
- imem_data  input  32  instruction at imem_addr, valid same cycle (combinational read).
- fd_insn  output  32  latched instruction word.
- fd_pc  output  PC_WIDTH  latched PC+1 of fd_insn (return address / branch base).
- fd_valid  output  1  fd_insn is a real instruction, not a bubble.
- fd_predicted  output  1  fd_insn is j/jal already redirected at fetch; downstream must not redirect again.

Behaviour:
- Reset, synchronous, highest priority:
  - pc <= RESET_PC; fd_insn <= 0; fd_pc <= 0; fd_valid <= 0; fd_predicted <= 0.
  - First valid instruction appears in fd_insn one cycle after reset deasserts.
- imem_addr = pc at all times, combinational.
- Instruction fields in fetch: op = imem_data[31:27], target = imem_data[26:0].
- early_jump = (op==00001) | (op==00011).
- seq_pc = pc + 1, truncated to PC_WIDTH; wraps to 0 from all-ones.
- Per-cycle priority, non-reset:
  1. redirect_valid=1 (also when stall=1):
     - pc <= redirect_pc.
     - fd_valid <= 0, fd_insn <= 0, fd_predicted <= 0, fd_pc <= 0.
     - Instruction currently at imem_data is discarded.
  2. stall=1, no redirect: pc and all fd_* registers hold their values.
  3. Normal advance:
     - fd_insn <= imem_data; fd_pc <= seq_pc; fd_valid <= 1; fd_predicted <= early_jump.
     - pc <= early_jump ? target[PC_WIDTH-1:0] : seq_pc.
     - Upper target bits above PC_WIDTH are ignored.
- Latency:
  - Fetch-to-F/D is 1 cycle.
  - j/jal target fetched the next cycle, zero bubbles.
  - Late redirect costs 1 bubble in F/D (fd_valid=0) plus whatever the pipeline flushes downstream.
- Bubble encoding is all-zero, i.e. an ALU op writing $0. Decode treats it as a NOP regardless of fd_valid.
- jal places PC+1 in fd_pc; the writeback of $31 uses fd_pc carried down the pipe.
- Early-jump opcode match covers only 00001 and 00011. 00100 (jr), 00010 (bne), 00110 (blt) and 10110 (bex) are resolved in execute through redirect_valid.
- Consecutive j instructions: each redirects in turn, no lost cycle.
- A j whose target equals its own PC re-fetches itself every cycle, with fd_valid=1 continuously.
- Reset asserted mid-stall or mid-redirect: reset wins; state returns to reset values the same edge.
- No X propagation: all registers have defined reset values. imem_data X while fd_valid is forced to 0 by redirect must not corrupt fd_insn.

Test Plan:
- Reset then sequential fetch, imem[n]=n with opcode 00000: after reset deasserts, imem_addr = 0,1,2,3 on successive cycles; fd_insn lags by 1; fd_pc = 1,2,3; fd_valid=1 from the second cycle.
- PC wrap, PC_WIDTH=12: force pc to 0xFFF via redirect_pc=0xFFF; next imem_addr=0x000 and fd_pc=0x000.
- Early jump, imem[4]=j 0x20 (0x08000020): cycle after fetching addr 4, imem_addr=0x020; fd_insn=0x08000020, fd_predicted=1, fd_pc=5; no bubble.
- jal at addr 7 to 0x100: fd_pc=8, fd_predicted=1, next imem_addr=0x100.
- Stall held 3 cycles at pc=10: imem_addr stays 10, fd_* unchanged. On release, fetch resumes with fd_pc=11.
- redirect_valid=1 with redirect_pc=0x40 while stall=1: next cycle imem_addr=0x40, fd_valid=0, fd_insn=0, fd_predicted=0. The following cycle fd_insn=imem[0x40].
- Reset asserted during a redirect cycle: next cycle pc=RESET_PC and all fd_* = 0.
